sequence_arbiter_serializer: RTL and testbench

//  N-channel successor to the 2-input muxer + sequence_to_bytes pair on the host-bound path.
//  - Arbitrates CHANNELS sources of {count,bytes} key/mouse sequences (fixed-priority or round-robin).
//  - Captures one whole sequence at a time and emits its bytes, paced for serial_out.
//  - Sits between the per-source sequence FIFOs and serial_out.

---
 rtl/sequence_arbiter_serializer_pkg.sv | 19 +
 rtl/sequence_arbiter_serializer_rr_arbiter.sv | 47 ++++
 rtl/sequence_arbiter_serializer.sv | 135 +++++++++++++
 tb/tb_sequence_arbiter_serializer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sequence_arbiter_serializer_pkg.sv
// Shared types and width helpers for the sequence arbiter/serializer and its arbiter.
// A slot is {count, payload}: the count field sits directly above the 8*SEQ_BYTES payload.
package sequence_arbiter_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_HOLD = 2'd2
  } ser_state_e;

  function automatic int slot_width(input int count_width, input int seq_bytes);
    return count_width + 8 * seq_bytes;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sequence_arbiter_serializer_rr_arbiter.sv
// One-hot grant over CHANNELS requests, either round-robin or fixed lowest-index priority.
// The last-grant pointer advances only when the grant is accepted.
module sequence_arbiter_serializer_rr_arbiter
  import sequence_arbiter_serializer_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int ROUND_ROBIN = 1,
  localparam int IW         = idx_width(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] req_i,
  input  logic                accept_i,
  output logic [CHANNELS-1:0] grant_o,
  output logic [IW-1:0]       grant_idx_o
);

  logic [IW-1:0] last_q;
  logic          found;
  int            c;

  // Round-robin search starts one past the last winner, wrapping modulo CHANNELS.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    c           = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ROUND_ROBIN != 0) c = (int'(last_q) + 1 + k) % CHANNELS;
      else                  c = k;
      if (!found && req_i[c]) begin
        found       = 1'b1;
        grant_o[c]  = 1'b1;
        grant_idx_o = IW'(c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_q <= IW'(CHANNELS - 1);
    end else if (accept_i && found) begin
      last_q <= grant_idx_o;
    end
  end

endmodule

// File: rtl/sequence_arbiter_serializer.sv
// Arbitrates CHANNELS {count,payload} sequences, captures one at a time and emits its bytes
// LSB-first with HOLDOFF idle cycles after each byte. Handshake: slot i transfers when in_available[i] & in_ready[i].
module sequence_arbiter_serializer
  import sequence_arbiter_serializer_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int SEQ_BYTES   = 4,
  parameter int COUNT_WIDTH = 3,
  parameter int ROUND_ROBIN = 1,
  parameter int HOLDOFF     = 2,
  localparam int SW         = slot_width(COUNT_WIDTH, SEQ_BYTES),
  localparam int PW         = 8 * SEQ_BYTES,
  localparam int IW         = idx_width(CHANNELS),
  localparam int HW         = $clog2(HOLDOFF + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [CHANNELS*SW-1:0] in_sequence,
  input  logic [CHANNELS-1:0]    in_available,
  output logic [CHANNELS-1:0]    in_ready,
  input  logic                   receiver_ready,
  output logic                   out_data_available,
  output logic [7:0]             out_data,
  output logic [IW-1:0]          active_channel,
  output logic                   busy,
  output logic [1:0]             state_dbg
);

  ser_state_e             state_q, state_d;
  logic [PW-1:0]          payload_q, payload_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] idx_q, idx_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [IW-1:0]          chan_q, chan_d;

  logic [CHANNELS-1:0]    grant;
  logic [IW-1:0]          grant_idx;
  logic                   accept;
  logic [SW-1:0]          slot;
  logic [COUNT_WIDTH-1:0] slot_cnt;
  logic [COUNT_WIDTH-1:0] cnt_clamped;
  logic [7:0]             byte_sel;

  sequence_arbiter_serializer_rr_arbiter #(
    .CHANNELS   (CHANNELS),
    .ROUND_ROBIN(ROUND_ROBIN)
  ) u_arb (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_i      (in_available),
    .accept_i   (accept),
    .grant_o    (grant),
    .grant_idx_o(grant_idx)
  );

  // Grant is one-hot, so OR-ing the masked slots selects the winner.
  always_comb begin
    slot = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) slot = slot | in_sequence[i*SW +: SW];
    end
  end

  assign slot_cnt    = slot[PW +: COUNT_WIDTH];
  assign cnt_clamped = (int'(slot_cnt) > SEQ_BYTES) ? COUNT_WIDTH'(SEQ_BYTES) : slot_cnt;

  always_comb begin
    state_d   = state_q;
    payload_d = payload_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    chan_d    = chan_q;
    accept    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|in_available) begin
          accept    = 1'b1;
          payload_d = slot[PW-1:0];
          cnt_d     = cnt_clamped;
          idx_d     = '0;
          chan_d    = grant_idx;
          // Zero-length sequences are consumed but never enter EMIT.
          if (cnt_clamped != '0) state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (receiver_ready) begin
          idx_d   = idx_q + 1'b1;
          hold_d  = '0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (hold_q == HW'(HOLDOFF - 1)) state_d = (idx_q < cnt_q) ? ST_EMIT : ST_IDLE;
        else                            hold_d  = hold_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      payload_q <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      chan_q    <= '0;
    end else begin
      state_q   <= state_d;
      payload_q <= payload_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      chan_q    <= chan_d;
    end
  end

  always_comb begin
    byte_sel = '0;
    for (int b = 0; b < SEQ_BYTES; b++) begin
      if (idx_q == COUNT_WIDTH'(b)) byte_sel = payload_q[8*b +: 8];
    end
  end

  // Gating with reset_n keeps a reset cycle from leaking a partial strobe or handshake.
  assign out_data_available = reset_n && (state_q == ST_EMIT) && receiver_ready;
  assign out_data           = out_data_available ? byte_sel : 8'h00;
  assign in_ready           = (reset_n && (state_q == ST_IDLE)) ? grant : '0;
  assign active_channel     = chan_q;
  assign busy               = (state_q != ST_IDLE);
  assign state_dbg          = state_q;

endmodule

// File: tb/tb_sequence_arbiter_serializer.sv
// Directed bench: instance A is round-robin, instance B fixed priority, both 3 channels x 4 bytes.
module tb_sequence_arbiter_serializer;

  localparam int CH = 3;
  localparam int SW = 35;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             rst_a, rst_b;
  logic [CH*SW-1:0] seq_a, seq_b;
  logic [CH-1:0]    av_a, av_b, inr_a, inr_b;
  logic             rr_a, rr_b;
  logic             strb_a, strb_b, busy_a, busy_b;
  logic [7:0]       data_a, data_b;
  logic [1:0]       ch_a, ch_b, st_a, st_b;

  sequence_arbiter_serializer #(
    .CHANNELS(CH), .SEQ_BYTES(4), .COUNT_WIDTH(3), .ROUND_ROBIN(1), .HOLDOFF(2)
  ) dut_a (
    .clk(clk), .reset_n(rst_a), .in_sequence(seq_a), .in_available(av_a), .in_ready(inr_a),
    .receiver_ready(rr_a), .out_data_available(strb_a), .out_data(data_a),
    .active_channel(ch_a), .busy(busy_a), .state_dbg(st_a)
  );

  sequence_arbiter_serializer #(
    .CHANNELS(CH), .SEQ_BYTES(4), .COUNT_WIDTH(3), .ROUND_ROBIN(0), .HOLDOFF(2)
  ) dut_b (
    .clk(clk), .reset_n(rst_b), .in_sequence(seq_b), .in_available(av_b), .in_ready(inr_b),
    .receiver_ready(rr_b), .out_data_available(strb_b), .out_data(data_b),
    .active_channel(ch_b), .busy(busy_b), .state_dbg(st_b)
  );

  // scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] a_q[$];
  int         a_t[$];
  logic [7:0] b_q[$];
  int         a_rdy_cnt[CH];
  int         b_rdy_cnt[CH];
  int         onehot_viol = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  always @(negedge clk) begin
    if (strb_a) begin a_q.push_back(data_a); a_t.push_back(cyc); end
    if (strb_b) b_q.push_back(data_b);
    for (int i = 0; i < CH; i++) begin
      if (inr_a[i]) a_rdy_cnt[i]++;
      if (inr_b[i]) b_rdy_cnt[i]++;
    end
    if (!$onehot0(inr_a) || !$onehot0(inr_b)) onehot_viol++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic compare_a(input string tag);
    check($sformatf("%s_count", tag), a_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), (i < a_q.size()) ? {24'h0, a_q[i]} : 32'hFFFF_FFFF,
            {24'h0, exp_q[i]});
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_slot_a(input int ch, input logic [2:0] cnt, input logic [31:0] pl);
    seq_a[ch*SW +: SW] = {cnt, pl};
  endtask

  task automatic set_slot_b(input int ch, input logic [2:0] cnt, input logic [31:0] pl);
    seq_b[ch*SW +: SW] = {cnt, pl};
  endtask

  task automatic reset_a();
    @(posedge clk); #1;
    rst_a = 1'b0; av_a = '0; seq_a = '0; rr_a = 1'b1;
    tick(2);
    rst_a = 1'b1;
    a_q.delete(); a_t.delete(); exp_q.delete();
    for (int i = 0; i < CH; i++) a_rdy_cnt[i] = 0;
  endtask

  task automatic wait_a(input int n, input int bound);
    for (int i = 0; i < bound && a_q.size() < n; i++) @(negedge clk);
  endtask

  int c0, r0;

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; seq_a = '0; seq_b = '0;
    av_a = '0; av_b = '0; rr_a = 1'b1; rr_b = 1'b1;
    tick(3);
    @(negedge clk);
    check("rst_strobe", strb_a, 1'b0);
    check("rst_data", data_a, 8'h00);
    check("rst_chan", ch_a, 2'd0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_inready", inr_a, 3'b000);
    @(posedge clk); #1;
    rst_a = 1'b1; rst_b = 1'b1;

    // two-byte sequence on ch0: 41 then 42, one cycle latency, 3-cycle spacing
    reset_a();
    set_slot_a(0, 3'd2, 32'h0000_4241);
    av_a = 3'b001;
    @(negedge clk);
    c0 = cyc;
    check("t1_inready", inr_a, 3'b001);
    tick(1);
    av_a = '0;
    wait_a(2, 40);
    tick(5);
    @(negedge clk);
    exp_q = '{8'h41, 8'h42};
    compare_a("t1");
    if (a_t.size() >= 2) begin
      check("t1_latency", a_t[0] - c0, 1);
      check("t1_spacing", a_t[1] - a_t[0], 3);
    end
    check("t1_busy_idle", busy_a, 1'b0);

    // round-robin with all three channels requesting continuously
    reset_a();
    for (int ch = 0; ch < CH; ch++) set_slot_a(ch, 3'd1, ch);
    av_a = 3'b111;
    wait_a(6, 80);
    tick(1);
    av_a = '0;
    tick(10);
    exp_q = '{8'h00, 8'h01, 8'h02, 8'h00, 8'h01, 8'h02};
    compare_a("t2_rr");

    // fixed priority: ch0 and ch2 requesting, ch2 starves until ch0 drops
    @(posedge clk); #1;
    rst_b = 1'b0;
    tick(2);
    rst_b = 1'b1;
    b_q.delete();
    for (int i = 0; i < CH; i++) b_rdy_cnt[i] = 0;
    set_slot_b(0, 3'd1, 32'h0000_00A0);
    set_slot_b(2, 3'd1, 32'h0000_00C2);
    av_b = 3'b101;
    tick(30);
    @(negedge clk);
    check("t3_served", b_q.size() >= 5, 1'b1);
    check("t3_ch2_starved", b_rdy_cnt[2], 0);
    for (int i = 0; i < b_q.size(); i++) check($sformatf("t3_byte%0d", i), b_q[i], 8'hA0);
    @(posedge clk); #1;
    av_b = 3'b100;
    tick(10);
    av_b = '0;
    tick(5);
    @(negedge clk);
    check("t3_ch2_served", b_rdy_cnt[2] > 0, 1'b1);
    check("t3_last_byte", (b_q.size() > 0) ? b_q[b_q.size()-1] : 8'h00, 8'hC2);

    // zero-count sequence is consumed silently
    reset_a();
    set_slot_a(1, 3'd0, 32'hFFFF_FFFF);
    av_a = 3'b010;
    @(negedge clk);
    check("t4_inready", inr_a, 3'b010);
    tick(1);
    av_a = '0;
    tick(8);
    @(negedge clk);
    check("t4_no_strobe", a_q.size(), 0);
    check("t4_busy", busy_a, 1'b0);
    check("t4_pulse_once", a_rdy_cnt[1], 1);

    // count 7 clamps to 4 bytes
    set_slot_a(0, 3'd7, 32'h4433_2211);
    @(posedge clk); #1;
    av_a = 3'b001;
    tick(1);
    av_a = '0;
    wait_a(4, 60);
    tick(10);
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    compare_a("t4_clamp");

    // receiver stall for 50 cycles after the first byte
    reset_a();
    set_slot_a(2, 3'd4, 32'hDDCC_BBAA);
    av_a = 3'b100;
    tick(1);
    av_a = '0;
    wait_a(1, 20);
    tick(1);
    rr_a = 1'b0;
    set_slot_a(0, 3'd1, 32'h0000_0077);
    av_a = 3'b001;
    r0 = a_rdy_cnt[0] + a_rdy_cnt[1] + a_rdy_cnt[2];
    tick(50);
    @(negedge clk);
    check("t5_stall_bytes", a_q.size(), 1);
    check("t5_stall_busy", busy_a, 1'b1);
    check("t5_stall_chan", ch_a, 2'd2);
    check("t5_stall_inready", a_rdy_cnt[0] + a_rdy_cnt[1] + a_rdy_cnt[2] - r0, 0);
    av_a = '0;
    rr_a = 1'b1;
    wait_a(4, 40);
    tick(8);
    exp_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    compare_a("t5_resume");

    // reset during the second byte of a 4-byte sequence
    reset_a();
    set_slot_a(1, 3'd4, 32'h0403_0201);
    av_a = 3'b010;
    tick(1);
    av_a = '0;
    wait_a(2, 20);
    tick(1);
    rst_a = 1'b0;
    tick(2);
    rst_a = 1'b1;
    tick(20);
    @(negedge clk);
    check("t6_bytes_after_rst", a_q.size(), 2);
    check("t6_busy", busy_a, 1'b0);
    set_slot_a(0, 3'd1, 32'h0000_0055);
    @(posedge clk); #1;
    av_a = 3'b011;
    @(negedge clk);
    check("t6_grant_ch0", inr_a, 3'b001);
    tick(1);
    av_a = '0;
    @(negedge clk);
    check("t6_active_ch0", ch_a, 2'd0);
    check("t6_busy_again", busy_a, 1'b1);
    tick(10);

    check("inready_onehot", onehot_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
